// File: rtl/hmc_pkg.sv
// ============================================================================
//  Package     : hmc_pkg
//  Description : Shared types and constants for the hmc-6502 interrupt path.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package hmc_pkg;

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_DUMMY     = 3'd1,
        ST_PUSH_H    = 3'd2,
        ST_PUSH_L    = 3'd3,
        ST_PUSH_P    = 3'd4,
        ST_VEC_LO    = 3'd5,
        ST_VEC_HI    = 3'd6,
        ST_RESET_ENT = 3'd7
    } int_state_t;

    typedef enum logic [1:0] {
        SRC_RES = 2'd0,
        SRC_NMI = 2'd1,
        SRC_IRQ = 2'd2,
        SRC_BRK = 2'd3
    } int_src_t;

    localparam logic [1:0]  c_PUSH_PCH = 2'b00;
    localparam logic [1:0]  c_PUSH_PCL = 2'b01;
    localparam logic [1:0]  c_PUSH_P   = 2'b10;

    localparam logic [15:0] c_VEC_NMI  = 16'hFFFA;
    localparam logic [15:0] c_VEC_RES  = 16'hFFFC;
    localparam logic [15:0] c_VEC_IRQ  = 16'hFFFE;

endpackage

`default_nettype wire

// File: rtl/nmi_edge_det.sv
// ============================================================================
//  Module      : nmi_edge_det
//  Description : NMI falling-edge detector with pending latch; set beats clear.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module nmi_edge_det (
    input  logic ph2,
    input  logic reset,
    input  logic nmi_n,
    input  logic clr,
    output logic nmi_pend
);

    logic r_nmi_q;
    logic r_nmi_pend;

    always_ff @(posedge ph2 or negedge reset) begin
        if (!reset) begin
            r_nmi_q    <= 1'b1;
            r_nmi_pend <= 1'b0;
        end else begin
            r_nmi_q <= nmi_n;
            if (r_nmi_q && !nmi_n) begin
                r_nmi_pend <= 1'b1;
            end else if (clr) begin
                r_nmi_pend <= 1'b0;
            end
        end
    end

    assign nmi_pend = r_nmi_pend;

endmodule

`default_nettype wire

// File: rtl/int_sequencer.sv
// ============================================================================
//  Module      : int_sequencer
//  Description : RESET/NMI/IRQ/BRK arbitration and 7-cycle vector entry sequence.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module int_sequencer
    import hmc_pkg::*;
#(
    parameter logic [15:0] VEC_NMI = c_VEC_NMI,
    parameter logic [15:0] VEC_RES = c_VEC_RES,
    parameter logic [15:0] VEC_IRQ = c_VEC_IRQ
) (
    input  logic        ph2,
    input  logic        reset,
    input  logic        nmi_n,
    input  logic        irq_n,
    input  logic        i_flag,
    input  logic        last_cycle,
    input  logic        brk_op,
    output logic        force_brk,
    output logic        busy,
    output logic        hold_pc,
    output logic        push_en,
    output logic [1:0]  push_sel,
    output logic        sp_dec,
    output logic        b_flag,
    output logic        vec_rd,
    output logic [15:0] vec_addr,
    output logic        pc_ld_lo,
    output logic        pc_ld_hi,
    output logic        set_i
);

    int_state_t  r_state;
    int_src_t    r_src;
    logic        r_nmi_vec;

    logic        w_nmi_pend;
    logic        w_irq_req;
    logic        w_hw_src;
    logic        w_nmi_vec;
    logic        w_use_nmi;
    logic        w_nmi_clr;
    logic [15:0] w_base;

    nmi_edge_det u_nmi_edge_det (
        .ph2      (ph2),
        .reset    (reset),
        .nmi_n    (nmi_n),
        .clr      (w_nmi_clr),
        .nmi_pend (w_nmi_pend)
    );

    assign w_irq_req = ~irq_n & ~i_flag;
    assign w_hw_src  = (r_src != SRC_BRK);

    // A pending NMI seen in VEC_LO steals a BRK/IRQ entry; the choice is frozen for VEC_HI.
    assign w_nmi_vec = (r_src == SRC_NMI) |
                       (((r_src == SRC_BRK) | (r_src == SRC_IRQ)) & w_nmi_pend);
    assign w_use_nmi = (r_state == ST_VEC_LO) ? w_nmi_vec : r_nmi_vec;
    assign w_nmi_clr = (r_state == ST_VEC_LO) & w_nmi_vec;

    always_comb begin
        if (w_use_nmi) begin
            w_base = VEC_NMI;
        end else if (r_src == SRC_RES) begin
            w_base = VEC_RES;
        end else begin
            w_base = VEC_IRQ;
        end
    end

    always_ff @(posedge ph2 or negedge reset) begin
        if (!reset) begin
            r_state   <= ST_RESET_ENT;
            r_src     <= SRC_RES;
            r_nmi_vec <= 1'b0;
        end else begin
            case (r_state)
                ST_RESET_ENT: begin
                    r_state   <= ST_DUMMY;
                    r_src     <= SRC_RES;
                    r_nmi_vec <= 1'b0;
                end
                ST_IDLE: begin
                    if (last_cycle && w_nmi_pend) begin
                        r_state <= ST_DUMMY;
                        r_src   <= SRC_NMI;
                    end else if (brk_op) begin
                        r_state <= ST_DUMMY;
                        r_src   <= SRC_BRK;
                    end else if (last_cycle && w_irq_req) begin
                        r_state <= ST_DUMMY;
                        r_src   <= SRC_IRQ;
                    end
                    r_nmi_vec <= 1'b0;
                end
                ST_DUMMY:  r_state <= ST_PUSH_H;
                ST_PUSH_H: r_state <= ST_PUSH_L;
                ST_PUSH_L: r_state <= ST_PUSH_P;
                ST_PUSH_P: r_state <= ST_VEC_LO;
                ST_VEC_LO: begin
                    r_state   <= ST_VEC_HI;
                    r_nmi_vec <= w_nmi_vec;
                end
                ST_VEC_HI: r_state <= ST_IDLE;
                default:   r_state <= ST_IDLE;
            endcase
        end
    end

    always_comb begin
        force_brk = 1'b0;
        busy      = 1'b0;
        hold_pc   = 1'b0;
        push_en   = 1'b0;
        push_sel  = c_PUSH_PCH;
        sp_dec    = 1'b0;
        b_flag    = 1'b0;
        vec_rd    = 1'b0;
        vec_addr  = 16'h0000;
        pc_ld_lo  = 1'b0;
        pc_ld_hi  = 1'b0;
        set_i     = 1'b0;
        case (r_state)
            ST_DUMMY: begin
                busy      = 1'b1;
                force_brk = w_hw_src;
                hold_pc   = w_hw_src;
            end
            ST_PUSH_H, ST_PUSH_L, ST_PUSH_P: begin
                busy    = 1'b1;
                sp_dec  = 1'b1;
                // Reset still walks SP down three bytes but never writes memory.
                push_en = (r_src != SRC_RES);
                b_flag  = (r_src == SRC_BRK);
                if (r_state == ST_PUSH_H) begin
                    push_sel = c_PUSH_PCH;
                end else if (r_state == ST_PUSH_L) begin
                    push_sel = c_PUSH_PCL;
                end else begin
                    push_sel = c_PUSH_P;
                end
            end
            ST_VEC_LO: begin
                busy     = 1'b1;
                vec_rd   = 1'b1;
                vec_addr = w_base;
                pc_ld_lo = 1'b1;
                set_i    = 1'b1;
            end
            ST_VEC_HI: begin
                busy     = 1'b1;
                vec_rd   = 1'b1;
                vec_addr = w_base + 16'd1;
                pc_ld_hi = 1'b1;
            end
            default: ;
        endcase
    end

endmodule

`default_nettype wire

// File: tb/tb_int_sequencer.sv
// ============================================================================
//  Module      : tb_int_sequencer
//  Description : Self-checking bench for int_sequencer against a trace model.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_int_sequencer;

    localparam int T_RES = 0;
    localparam int T_NMI = 1;
    localparam int T_IRQ = 2;
    localparam int T_BRK = 3;

    logic        ph2 = 1'b0;
    logic        reset;
    logic        nmi_n;
    logic        irq_n;
    logic        i_flag;
    logic        last_cycle;
    logic        brk_op;
    logic        force_brk;
    logic        busy;
    logic        hold_pc;
    logic        push_en;
    logic [1:0]  push_sel;
    logic        sp_dec;
    logic        b_flag;
    logic        vec_rd;
    logic [15:0] vec_addr;
    logic        pc_ld_lo;
    logic        pc_ld_hi;
    logic        set_i;

    logic [27:0] obs;
    logic [27:0] cap [7];
    logic [7:0]  sp;
    int          n_cmp = 0;
    int          n_fail = 0;

    int_sequencer dut (
        .ph2        (ph2),
        .reset      (reset),
        .nmi_n      (nmi_n),
        .irq_n      (irq_n),
        .i_flag     (i_flag),
        .last_cycle (last_cycle),
        .brk_op     (brk_op),
        .force_brk  (force_brk),
        .busy       (busy),
        .hold_pc    (hold_pc),
        .push_en    (push_en),
        .push_sel   (push_sel),
        .sp_dec     (sp_dec),
        .b_flag     (b_flag),
        .vec_rd     (vec_rd),
        .vec_addr   (vec_addr),
        .pc_ld_lo   (pc_ld_lo),
        .pc_ld_hi   (pc_ld_hi),
        .set_i      (set_i)
    );

    always #5 ph2 = ~ph2;

    assign obs = {force_brk, busy, hold_pc, push_en, push_sel, sp_dec, b_flag,
                  vec_rd, vec_addr, pc_ld_lo, pc_ld_hi, set_i};

    // Expected outputs k cycles after the start edge (k=6 is back to idle).
    function automatic logic [27:0] exp_at(input int src, input logic [15:0] base, input int k);
        logic fb, bsy, hp, pe, sd, bf, vr, ll, lh, si;
        logic [1:0]  ps;
        logic [15:0] va;
        {fb, bsy, hp, pe, sd, bf, vr, ll, lh, si} = '0;
        ps = 2'b00;
        va = 16'h0000;
        bsy = (k >= 0) && (k <= 5);
        case (k)
            0: begin
                fb = (src != T_BRK);
                hp = (src != T_BRK);
            end
            1, 2, 3: begin
                sd = 1'b1;
                pe = (src != T_RES);
                ps = 2'(k - 1);
                bf = (src == T_BRK);
            end
            4: begin
                vr = 1'b1;
                va = base;
                ll = 1'b1;
                si = 1'b1;
            end
            5: begin
                vr = 1'b1;
                va = base + 16'd1;
                lh = 1'b1;
            end
            default: ;
        endcase
        return {fb, bsy, hp, pe, ps, sd, bf, vr, va, ll, lh, si};
    endfunction

    // External SP follows sp_dec across each edge.
    task automatic cyc();
        if (sp_dec) sp = sp - 8'd1;
        @(posedge ph2);
        #1;
    endtask

    // Start edge, then record seven cycles; optionally pulse nmi_n low after step nmi_at.
    task automatic capture_seq(input int nmi_at);
        cyc();
        brk_op     = 1'b0;
        last_cycle = 1'b0;
        irq_n      = 1'b1;
        nmi_n      = 1'b1;
        for (int k = 0; k < 7; k++) begin
            if (k > 0) cyc();
            cap[k] = obs;
            nmi_n  = (k == nmi_at) ? 1'b0 : 1'b1;
        end
    endtask

    task automatic test_reset();
        reset = 1'b1; nmi_n = 1'b1; irq_n = 1'b1; i_flag = 1'b0;
        last_cycle = 1'b0; brk_op = 1'b0; sp = 8'h00;
        #2 reset = 1'b0;
        repeat (2) @(posedge ph2);
        #1;
        n_cmp++;
        if (obs !== 28'h0) begin
            n_fail++;
            $display("FAIL reset_hold got %h want %h", obs, 28'h0);
        end
        #2 reset = 1'b1;
        capture_seq(-1);
        for (int k = 0; k < 7; k++) begin
            n_cmp++;
            if (cap[k] !== exp_at(T_RES, 16'hFFFC, k)) begin
                n_fail++;
                $display("FAIL reset_seq k=%0d got %h want %h", k, cap[k], exp_at(T_RES, 16'hFFFC, k));
            end
        end
        n_cmp++;
        if (sp !== 8'hFD) begin
            n_fail++;
            $display("FAIL reset_sp got %h want %h", sp, 8'hFD);
        end
    endtask

    task automatic test_irq();
        i_flag = 1'b0; irq_n = 1'b0; last_cycle = 1'b1;
        capture_seq(-1);
        for (int k = 0; k < 7; k++) begin
            n_cmp++;
            if (cap[k] !== exp_at(T_IRQ, 16'hFFFE, k)) begin
                n_fail++;
                $display("FAIL irq_seq k=%0d got %h want %h", k, cap[k], exp_at(T_IRQ, 16'hFFFE, k));
            end
        end
    endtask

    task automatic test_irq_masked();
        i_flag = 1'b1; irq_n = 1'b0;
        for (int b = 0; b < 10; b++) begin
            last_cycle = 1'b1;
            cyc();
            n_cmp++;
            if (obs !== 28'h0) begin
                n_fail++;
                $display("FAIL irq_masked b=%0d got %h want %h", b, obs, 28'h0);
            end
        end
        last_cycle = 1'b0; irq_n = 1'b1;
    endtask

    task automatic test_brk();
        i_flag = 1'b0; brk_op = 1'b1;
        capture_seq(-1);
        for (int k = 0; k < 7; k++) begin
            n_cmp++;
            if (cap[k] !== exp_at(T_BRK, 16'hFFFE, k)) begin
                n_fail++;
                $display("FAIL brk_seq k=%0d got %h want %h", k, cap[k], exp_at(T_BRK, 16'hFFFE, k));
            end
        end
    endtask

    task automatic test_nmi_vs_irq();
        i_flag = 1'b0; irq_n = 1'b0; nmi_n = 1'b0; last_cycle = 1'b0;
        cyc();
        n_cmp++;
        if (obs !== 28'h0) begin
            n_fail++;
            $display("FAIL nmi_wait got %h want %h", obs, 28'h0);
        end
        last_cycle = 1'b1;
        capture_seq(-1);
        for (int k = 0; k < 7; k++) begin
            n_cmp++;
            if (cap[k] !== exp_at(T_NMI, 16'hFFFA, k)) begin
                n_fail++;
                $display("FAIL nmi_seq k=%0d got %h want %h", k, cap[k], exp_at(T_NMI, 16'hFFFA, k));
            end
        end
    endtask

    task automatic test_hijack();
        i_flag = 1'b0; brk_op = 1'b1;
        capture_seq(2);
        for (int k = 0; k < 7; k++) begin
            n_cmp++;
            if (cap[k] !== exp_at(T_BRK, 16'hFFFA, k)) begin
                n_fail++;
                $display("FAIL hijack_seq k=%0d got %h want %h", k, cap[k], exp_at(T_BRK, 16'hFFFA, k));
            end
        end
        // The stolen NMI must be consumed: boundaries now stay idle.
        for (int b = 0; b < 3; b++) begin
            last_cycle = 1'b1;
            cyc();
            n_cmp++;
            if (obs !== 28'h0) begin
                n_fail++;
                $display("FAIL hijack_consumed b=%0d got %h want %h", b, obs, 28'h0);
            end
        end
        last_cycle = 1'b0;
    endtask

    task automatic test_reset_mid();
        i_flag = 1'b0; irq_n = 1'b0; last_cycle = 1'b1;
        cyc();
        last_cycle = 1'b0; irq_n = 1'b1;
        repeat (3) cyc();
        n_cmp++;
        if (obs !== exp_at(T_IRQ, 16'hFFFE, 3)) begin
            n_fail++;
            $display("FAIL mid_push_p got %h want %h", obs, exp_at(T_IRQ, 16'hFFFE, 3));
        end
        reset = 1'b0;
        #1;
        n_cmp++;
        if (obs !== 28'h0) begin
            n_fail++;
            $display("FAIL mid_abort got %h want %h", obs, 28'h0);
        end
        @(posedge ph2);
        #1;
        n_cmp++;
        if (obs !== 28'h0) begin
            n_fail++;
            $display("FAIL mid_abort_hold got %h want %h", obs, 28'h0);
        end
        reset = 1'b1;
        sp = 8'h00;
        capture_seq(-1);
        for (int k = 0; k < 7; k++) begin
            n_cmp++;
            if (cap[k] !== exp_at(T_RES, 16'hFFFC, k)) begin
                n_fail++;
                $display("FAIL mid_reset_seq k=%0d got %h want %h", k, cap[k], exp_at(T_RES, 16'hFFFC, k));
            end
        end
    endtask

    task automatic test_random();
        int          pend = 0;
        int          src;
        logic [15:0] base;
        logic        b, lc, il, fl;
        for (int it = 0; it < 30; it++) begin
            brk_op = 1'b0; last_cycle = 1'b0; irq_n = 1'b1; nmi_n = 1'b1;
            for (int g = 0; g < int'($urandom_range(0, 2)); g++) begin
                cyc();
                n_cmp++;
                if (obs !== 28'h0) begin
                    n_fail++;
                    $display("FAIL rand_gap it=%0d got %h want %h", it, obs, 28'h0);
                end
            end
            if ($urandom_range(0, 2) == 0) begin
                nmi_n = 1'b0;
                cyc();
                pend = 1;
                nmi_n = 1'b1;
                n_cmp++;
                if (obs !== 28'h0) begin
                    n_fail++;
                    $display("FAIL rand_nmi_wait it=%0d got %h want %h", it, obs, 28'h0);
                end
            end
            b  = ($urandom_range(0, 2) == 0);
            lc = 1'($urandom_range(0, 1));
            il = 1'($urandom_range(0, 1));
            fl = 1'($urandom_range(0, 1));
            brk_op = b; last_cycle = lc; irq_n = ~il; i_flag = fl;
            if (lc && pend != 0)    src = T_NMI;
            else if (b)             src = T_BRK;
            else if (lc && il && !fl) src = T_IRQ;
            else                    src = -1;
            if (src < 0) begin
                cyc();
                n_cmp++;
                if (obs !== 28'h0) begin
                    n_fail++;
                    $display("FAIL rand_idle it=%0d got %h want %h", it, obs, 28'h0);
                end
            end else begin
                base = (src == T_NMI || pend != 0) ? 16'hFFFA : 16'hFFFE;
                pend = 0;
                capture_seq(-1);
                for (int k = 0; k < 7; k++) begin
                    n_cmp++;
                    if (cap[k] !== exp_at(src, base, k)) begin
                        n_fail++;
                        $display("FAIL rand_seq it=%0d src=%0d k=%0d got %h want %h",
                                 it, src, k, cap[k], exp_at(src, base, k));
                    end
                end
            end
        end
        brk_op = 1'b0; last_cycle = 1'b0; irq_n = 1'b1; nmi_n = 1'b1;
    endtask

    initial begin
        test_reset();
        test_irq();
        test_irq_masked();
        test_brk();
        test_nmi_vs_irq();
        test_hijack();
        test_reset_mid();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
